// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter feeding the register file write port.
// The ALU and LSU results each land in a one-entry holding slot. The oldest
// full slot is granted onto a registered write port. A pending mask lets
// issue logic see every write that is still in flight.

// One-entry holding slot for a single result source
module wb_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  grant_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  // A load wins over a drain, so a granted slot can refill on the same edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_o <= 1'b0;
      addr_o <= '0;
      data_o <= '0;
    end else if (load_i) begin
      full_o <= 1'b1;
      addr_o <= waddr_i;
      data_o <= wdata_i;
    end else if (grant_i) begin
      full_o <= 1'b0;
    end
  end

endmodule

module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [ADDR_WIDTH-1:0]    alu_waddr_i,
  input  logic [DATA_WIDTH-1:0]    alu_wdata_i,
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]    lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]    lsu_wdata_i,
  output logic                     we_o,
  output logic [ADDR_WIDTH-1:0]    waddr_o,
  output logic [DATA_WIDTH-1:0]    wdata_o,
  output logic [2**ADDR_WIDTH-1:0] pending_o
);

  // Source index 0 is the ALU, index 1 is the LSU
  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0]                 in_valid, ready, load, grant, full_q;
  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] in_addr, addr_q;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] in_data, data_q;
  logic                               older_q, older_d;
  logic                               sel;

  assign in_valid = {lsu_valid_i, alu_valid_i};
  assign in_addr  = {lsu_waddr_i, alu_waddr_i};
  assign in_data  = {lsu_wdata_i, alu_wdata_i};

  // Ready depends only on slot state and the grant, never on valid.
  // It is forced low while reset is held.
  assign ready       = {NUM_SRC{rst_ni}} & (~full_q | grant);
  assign load        = in_valid & ready;
  assign alu_ready_o = ready[0];
  assign lsu_ready_o = ready[1];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_slot
    wb_slot #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_slot (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (load[s]),
      .grant_i(grant[s]),
      .waddr_i(in_addr[s]),
      .wdata_i(in_data[s]),
      .full_o (full_q[s]),
      .addr_o (addr_q[s]),
      .data_o (data_q[s])
    );
  end

  // Oldest-first grant taken from registered slot state only
  always_comb begin
    grant = '0;
    case (full_q)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant[older_q] = 1'b1;
      default: grant = '0;
    endcase
  end

  // Age tracking: a slot that stays full behind a newer load becomes the
  // older one. When both slots load together, the ALU counts as older.
  always_comb begin
    older_d = older_q;
    if (load == 2'b11)                          older_d = 1'b0;
    else if (load[0] && full_q[1] && !grant[1]) older_d = 1'b1;
    else if (load[1] && full_q[0] && !grant[0]) older_d = 1'b0;
  end

  // Age flag register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) older_q <= 1'b0;
    else         older_q <= older_d;
  end

  assign sel = grant[1];

  // Registered write port. Writes to r0 still move the address and data
  // onto the port but never raise the enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (|grant) begin
      we_o    <= (addr_q[sel] != '0);
      waddr_o <= addr_q[sel];
      wdata_o <= data_q[sel];
    end else begin
      we_o    <= 1'b0;
    end
  end

  // Pending mask covers buffered writes and the write on the port; r0 never counts
  always_comb begin
    pending_o = '0;
    for (int s = 0; s < NUM_SRC; s++)
      if (full_q[s]) pending_o[addr_q[s]] = 1'b1;
    if (we_o) pending_o[waddr_o] = 1'b1;
    pending_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboarded bench for regfile_wb_arbiter. The bench records accepted writes
// in acceptance order, with the ALU ahead of the LSU when both are accepted on
// the same edge. Each we_o pulse must match the next non-r0 entry.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          alu_valid_i = 1'b0, lsu_valid_i = 1'b0;
  logic [AW-1:0] alu_waddr_i = '0, lsu_waddr_i = '0;
  logic [DW-1:0] alu_wdata_i = '0, lsu_wdata_i = '0;
  logic          alu_ready_o, lsu_ready_o, we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;
  logic [2**AW-1:0] pending_o;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sbq[$];
  logic [DW-1:0] rf [2**AW];
  int            n_tests = 0, n_fail = 0;
  int            we_run = 0, we_max = 0;

  // Monitor: check each write pulse against the scoreboard, then record new handshakes
  always @(negedge clk_i) begin
    wr_t e;
    if (!rst_ni) begin
      sbq.delete();
      we_run = 0;
    end else begin
      if (we_o) begin
        while (sbq.size() > 0 && sbq[0].addr == '0) void'(sbq.pop_front());
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow got waddr=%0d wdata=%h, expected no write", waddr_o, wdata_o);
        end else begin
          e = sbq.pop_front();
          if (waddr_o !== e.addr || wdata_o !== e.data) begin
            n_fail++;
            $display("FAIL sb_order got waddr=%0d wdata=%h, expected waddr=%0d wdata=%h",
                     waddr_o, wdata_o, e.addr, e.data);
          end
        end
        rf[waddr_o] = wdata_o;
        we_run++;
        if (we_run > we_max) we_max = we_run;
      end else begin
        we_run = 0;
      end
      n_tests++;
      if (pending_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL pending_r0 got %b, expected 0", pending_o[0]);
      end
      if (alu_valid_i && alu_ready_o) begin e.addr = alu_waddr_i; e.data = alu_wdata_i; sbq.push_back(e); end
      if (lsu_valid_i && lsu_ready_o) begin e.addr = lsu_waddr_i; e.data = lsu_wdata_i; sbq.push_back(e); end
      // r0 writes never pulse we_o, so they are dropped once they reach the head
      while (sbq.size() > 0 && sbq[0].addr == '0) void'(sbq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b1; #1; rst_ni = 1'b0; #1;
    n_tests++;
    if (we_o !== 1'b0 || waddr_o !== '0 || wdata_o !== '0) begin
      n_fail++; $display("FAIL reset_port got we=%b waddr=%0d wdata=%h, expected 0/0/0", we_o, waddr_o, wdata_o);
    end
    n_tests++;
    if (pending_o !== '0) begin n_fail++; $display("FAIL reset_pending got %h, expected 0", pending_o); end
    n_tests++;
    if (alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %b%b, expected 00", alu_ready_o, lsu_ready_o);
    end
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1; #1;
    n_tests++;
    if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready got %b%b, expected 11", alu_ready_o, lsu_ready_o);
    end
  endtask

  task automatic test_single();
    tick(); alu_valid_i = 1'b1; alu_waddr_i = 5'd5; alu_wdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    n_tests++;
    if (pending_o[5] !== 1'b0 || we_o !== 1'b0) begin
      n_fail++; $display("FAIL single_pre got pend5=%b we=%b, expected 0/0", pending_o[5], we_o);
    end
    tick(); alu_valid_i = 1'b0;
    @(negedge clk_i);
    n_tests++;
    if (pending_o[5] !== 1'b1 || we_o !== 1'b0) begin
      n_fail++; $display("FAIL single_n got pend5=%b we=%b, expected 1/0", pending_o[5], we_o);
    end
    @(negedge clk_i);
    n_tests++;
    if (we_o !== 1'b1 || waddr_o !== 5'd5 || wdata_o !== 32'hDEADBEEF || pending_o[5] !== 1'b1) begin
      n_fail++; $display("FAIL single_n1 got we=%b waddr=%0d wdata=%h pend5=%b, expected 1/5/deadbeef/1",
                         we_o, waddr_o, wdata_o, pending_o[5]);
    end
    @(negedge clk_i);
    n_tests++;
    if (we_o !== 1'b0 || pending_o[5] !== 1'b0) begin
      n_fail++; $display("FAIL single_n2 got we=%b pend5=%b, expected 0/0", we_o, pending_o[5]);
    end
  endtask

  task automatic test_back_to_back();
    we_max = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(); alu_valid_i = 1'b1; alu_waddr_i = AW'(i); alu_wdata_i = $urandom;
      n_tests++;
      if (alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cycle %0d got 0, expected 1", i); end
    end
    tick(); alu_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    n_tests++;
    if (we_max != 8) begin n_fail++; $display("FAIL b2b_run got %0d consecutive writes, expected 8", we_max); end
    n_tests++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL b2b_drain got %0d left, expected 0", sbq.size()); end
  endtask

  task automatic test_same_edge();
    tick();
    alu_valid_i = 1'b1; alu_waddr_i = 5'd3; alu_wdata_i = 32'h11;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd3; lsu_wdata_i = 32'h22;
    n_tests++;
    if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL same_ready0 got %b%b, expected 11", alu_ready_o, lsu_ready_o);
    end
    tick(); alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    n_tests++;
    if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL same_ready1 got %b%b, expected 10", alu_ready_o, lsu_ready_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    n_tests++;
    if (we_o !== 1'b1 || waddr_o !== 5'd3 || wdata_o !== 32'h11) begin
      n_fail++; $display("FAIL same_first got we=%b waddr=%0d wdata=%h, expected 1/3/11", we_o, waddr_o, wdata_o);
    end
    @(negedge clk_i);
    n_tests++;
    if (we_o !== 1'b1 || waddr_o !== 5'd3 || wdata_o !== 32'h22) begin
      n_fail++; $display("FAIL same_second got we=%b waddr=%0d wdata=%h, expected 1/3/22", we_o, waddr_o, wdata_o);
    end
    repeat (2) @(negedge clk_i);
    n_tests++;
    if (rf[3] !== 32'h22) begin n_fail++; $display("FAIL same_rf3 got %h, expected 22", rf[3]); end
  endtask

  // Both sources held valid: after the tie, grants and readies must alternate
  task automatic test_alternate();
    logic af, lf, prev;
    prev = 1'b0;
    tick();
    alu_valid_i = 1'b1; alu_waddr_i = AW'($urandom_range(1, 31)); alu_wdata_i = $urandom;
    lsu_valid_i = 1'b1; lsu_waddr_i = AW'($urandom_range(1, 31)); lsu_wdata_i = $urandom;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_i);
      af = alu_valid_i && alu_ready_o;
      lf = lsu_valid_i && lsu_ready_o;
      tick();
      if (af) begin alu_waddr_i = AW'($urandom_range(1, 31)); alu_wdata_i = $urandom; end
      if (lf) begin lsu_waddr_i = AW'($urandom_range(1, 31)); lsu_wdata_i = $urandom; end
      n_tests++;
      if (alu_ready_o === lsu_ready_o || (c == 0 && alu_ready_o !== 1'b1) || (c > 0 && alu_ready_o === prev)) begin
        n_fail++; $display("FAIL alt_ready cycle %0d got %b%b, expected alternating one-hot", c, alu_ready_o, lsu_ready_o);
      end
      prev = alu_ready_o;
    end
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    n_tests++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL alt_drain got %0d left, expected 0", sbq.size()); end
  endtask

  task automatic test_random();
    logic af, lf;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      af = alu_valid_i && alu_ready_o;
      lf = lsu_valid_i && lsu_ready_o;
      tick();
      if (!alu_valid_i || af) begin
        alu_valid_i = ($urandom_range(0, 3) != 0);
        alu_waddr_i = AW'($urandom_range(0, 7)); alu_wdata_i = $urandom;
      end
      if (!lsu_valid_i || lf) begin
        lsu_valid_i = ($urandom_range(0, 2) != 0);
        lsu_waddr_i = AW'($urandom_range(0, 7)); lsu_wdata_i = $urandom;
      end
    end
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    n_tests++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL rand_drain got %0d left, expected 0", sbq.size()); end
  endtask

  task automatic test_reg0();
    tick(); alu_valid_i = 1'b1; alu_waddr_i = '0; alu_wdata_i = 32'hFFFFFFFF;
    n_tests++;
    if (alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL r0_ready got 0, expected 1"); end
    tick(); alu_valid_i = 1'b0;
    @(negedge clk_i);
    n_tests++;
    if (we_o !== 1'b0 || pending_o !== '0) begin
      n_fail++; $display("FAIL r0_buf got we=%b pending=%h, expected 0/0", we_o, pending_o);
    end
    @(negedge clk_i);
    n_tests++;
    if (we_o !== 1'b0 || waddr_o !== '0 || wdata_o !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL r0_port got we=%b waddr=%0d wdata=%h, expected 0/0/ffffffff", we_o, waddr_o, wdata_o);
    end
    @(negedge clk_i);
    n_tests++;
    if (we_o !== 1'b0) begin n_fail++; $display("FAIL r0_after got we=%b, expected 0", we_o); end
  endtask

  task automatic test_reset_mid();
    tick();
    alu_valid_i = 1'b1; alu_waddr_i = 5'd9;  alu_wdata_i = 32'hA9;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd10; lsu_wdata_i = 32'hBA;
    tick(); alu_waddr_i = 5'd11; alu_wdata_i = 32'hAB;
    tick();
    n_tests++;
    if (we_o !== 1'b1 || pending_o === '0) begin
      n_fail++; $display("FAIL mid_busy got we=%b pending=%h, expected busy", we_o, pending_o);
    end
    rst_ni = 1'b0; alu_valid_i = 1'b0; lsu_valid_i = 1'b0; #1;
    n_tests++;
    if (we_o !== 1'b0 || pending_o !== '0 || alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got we=%b pending=%h ready=%b%b, expected 0/0/00",
                         we_o, pending_o, alu_ready_o, lsu_ready_o);
    end
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1; #1;
    n_tests++;
    if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_release got %b%b, expected 11", alu_ready_o, lsu_ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_tests++;
      if (we_o !== 1'b0 || pending_o !== '0) begin
        n_fail++; $display("FAIL mid_spurious cycle %0d got we=%b pending=%h, expected 0/0", i, we_o, pending_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_same_edge();
    test_alternate();
    test_random();
    test_reg0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
